// File: rtl/oup_wb_pkg.sv
// oup_wb_pkg: shared types and widths for the Wishbone initiator
package oup_wb_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
  } wb_cmd_t;
  typedef enum logic [1:0] {IDLE, BUS, RESP} wb_init_state_t;
endpackage

// File: rtl/oup_wb_watchdog.sv
// oup_wb_watchdog: saturating bus-cycle counter flagging the abort cycle
module oup_wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable && cnt != '1) cnt <= cnt + 1'b1;
  end
  // A zero limit disables the watchdog entirely
  assign expired = (TIMEOUT_CYCLES != 0) && (32'(cnt) == TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/oup_wb_initiator.sv
// oup_wb_initiator: valid/ready command stream to single Wishbone classic cycles
module oup_wb_initiator
  import oup_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [2:0]  WB_TAG         = 3'b000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic [2:0]          wb_tag_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic                wb_we_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);
  wb_init_state_t state;
  wb_cmd_t        cmd;
  logic           expired;
  logic           accept;
  logic           done;
  assign accept   = state == IDLE && cmd_valid_i && cmd_ready_o;
  assign done     = wb_ack_i || wb_err_i || expired;
  assign wb_tag_o = WB_TAG;
  assign wb_we_o  = cmd.we;
  assign wb_adr_o = cmd.adr;
  assign wb_dat_o = cmd.dat;
  assign wb_sel_o = cmd.sel;
  oup_wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (accept),
    .enable (state == BUS),
    .expired(expired)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      cmd           <= '0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      cmd_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            cmd         <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            cmd_ready_o <= 1'b0;
            state       <= BUS;
          end
        end
        BUS: if (done) begin
          // A slave reply in the abort cycle outranks the watchdog; err outranks ack
          wb_cyc_o      <= 1'b0;
          wb_stb_o      <= 1'b0;
          cmd           <= '0;
          rsp_valid_o   <= 1'b1;
          rsp_err_o     <= wb_err_i || !wb_ack_i;
          rsp_timeout_o <= !wb_ack_i && !wb_err_i;
          rsp_dat_o     <= (wb_ack_i && !wb_err_i && !cmd.we) ? wb_dat_i : '0;
          state         <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o   <= 1'b0;
          rsp_dat_o     <= '0;
          rsp_err_o     <= 1'b0;
          rsp_timeout_o <= 1'b0;
          cmd_ready_o   <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oup_wb_initiator.sv
// tb_oup_wb_initiator: directed and randomized checks of the Wishbone initiator
module tb_oup_wb_initiator;
  localparam int unsigned TO = 8;
  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0] cmd_sel;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_dat;
  logic [2:0] wb_tag;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
  logic [3:0] wb_sel;
  int n_cmp = 0;
  int n_fail = 0;

  oup_wb_initiator #(.TIMEOUT_CYCLES(TO), .WB_TAG(3'b101)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .wb_tag_o(wb_tag), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we), .wb_sel_o(wb_sel), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    n_cmp++;
    if (!cmd_ready) begin n_fail++; $display("FAIL %s ready_wait: cmd_ready=%b required 1", name, cmd_ready); end
  endtask

  // One command, slave replies in bus cycle d (a=ack, e=err); response held off for wait_n cycles
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int d, input logic a, input logic e,
                         input logic [31:0] rdata, input int wait_n, input string name);
    bit ev;
    int exp_cyc, cyc_cnt, k;
    logic [33:0] exp_rsp;
    ev = (a || e) && d < int'(TO);
    exp_cyc = ev ? d + 1 : int'(TO);
    exp_rsp = {!ev || e, !ev, (ev && !e && !we) ? rdata : 32'h0};
    wait_ready(name);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom;
    n_cmp++;
    if (wb_cyc !== 1'b1) begin n_fail++; $display("FAIL %s latency: cyc=%b required 1 one cycle after accept", name, wb_cyc); end
    cyc_cnt = 0; k = 0;
    while (wb_cyc && k < 20) begin
      cyc_cnt++;
      n_cmp++;
      if ({wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel} !== {1'b1, we, adr, dat, sel}) begin
        n_fail++;
        $display("FAIL %s bus: stb=%b we=%b adr=%h dat=%h sel=%h required 1 %b %h %h %h",
                 name, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, we, adr, dat, sel);
      end
      wb_ack = (k == d) && a;
      wb_err = (k == d) && e;
      wb_dat_i = (k == d) ? rdata : $urandom;
      tick();
      wb_ack = 1'b0; wb_err = 1'b0;
      k++;
    end
    n_cmp++;
    if (cyc_cnt != exp_cyc) begin n_fail++; $display("FAIL %s cyc_len: got %0d required %0d", name, cyc_cnt, exp_cyc); end
    for (int j = 0; j <= wait_n; j++) begin
      n_cmp++;
      if ({rsp_valid, rsp_err, rsp_timeout, rsp_dat, cmd_ready, wb_cyc} !== {1'b1, exp_rsp, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s rsp[%0d]: valid=%b err=%b to=%b dat=%h ready=%b cyc=%b required 1 %b %b %h 0 0",
                 name, j, rsp_valid, rsp_err, rsp_timeout, rsp_dat, cmd_ready, wb_cyc,
                 exp_rsp[33], exp_rsp[32], exp_rsp[31:0]);
      end
      if (j < wait_n) begin cmd_valid = 1'b1; tick(); end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_dat, cmd_ready, wb_cyc} !== {3'b000, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s release: valid=%b err=%b to=%b dat=%h ready=%b cyc=%b required 0 0 0 0 1 0",
               name, rsp_valid, rsp_err, rsp_timeout, rsp_dat, cmd_ready, wb_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_dat, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b cyc=%b stb=%b adr=%h required all 0",
               cmd_ready, rsp_valid, wb_cyc, wb_stb, wb_adr);
    end
    n_cmp++;
    if (wb_tag !== 3'b101) begin n_fail++; $display("FAIL tag: got %b required 101", wb_tag); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_directed();
    run_txn(1'b1, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b1, 1'b0, 32'h0, 0, "write_ack2");
    run_txn(1'b0, 32'h9000_0004, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'h1234_5678, 0, "read_ack0");
    run_txn(1'b0, 32'h9000_0008, 32'h0, 4'h3, 1, 1'b1, 1'b1, 32'hCAFE_F00D, 0, "ack_err");
    run_txn(1'b0, 32'h9000_000C, 32'h0, 4'hF, 99, 1'b0, 1'b0, 32'h0, 0, "timeout");
    run_txn(1'b0, 32'h9000_0014, 32'h0, 4'hF, int'(TO) - 1, 1'b1, 1'b0, 32'hA5A5_5A5A, 0, "ack_abort_cycle");
    run_txn(1'b0, 32'h9000_0018, 32'h0, 4'hC, 0, 1'b1, 1'b0, 32'h0BAD_F00D, 5, "rsp_stall");
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++)
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 9),
              1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3), "random");
  endtask

  task automatic test_mid_reset();
    wait_ready("mid_reset");
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h9000_0020; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({wb_cyc, wb_stb, rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_drop: cyc=%b stb=%b valid=%b required 0 0 0", wb_cyc, wb_stb, rsp_valid);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({cmd_ready, rsp_valid, wb_cyc} !== 3'b100) begin
      n_fail++; $display("FAIL mid_reset_release: ready=%b valid=%b cyc=%b required 1 0 0", cmd_ready, rsp_valid, wb_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_norsp: valid=%b required 0", rsp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp;
    int accepts = 0, rsps = 0;
    rsp_ready = 1'b1; wb_ack = 1'b1; cmd_we = 1'b0;
    for (int i = 0; i < 36; i++) begin
      cmd_valid = i < 30;
      cmd_adr = $urandom; cmd_sel = 4'($urandom); wb_dat_i = $urandom;
      if (cmd_valid && cmd_ready) accepts++;
      if (wb_cyc) q.push_back(wb_dat_i);
      if (rsp_valid) begin
        rsps++;
        exp = q.size() > 0 ? q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        if ({rsp_err, rsp_dat} !== {1'b0, exp}) begin
          n_fail++; $display("FAIL b2b_data: err=%b dat=%h required 0 %h", rsp_err, rsp_dat, exp);
        end
      end
      tick();
    end
    cmd_valid = 1'b0; wb_ack = 1'b0; rsp_ready = 1'b0;
    n_cmp++;
    if (accepts != 10 || rsps != 10) begin
      n_fail++; $display("FAIL b2b_rate: accepts=%0d rsps=%0d required 10 10", accepts, rsps);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
